// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and constants for the fetch stage.
// Provides WORD_W, PC_INC, NOP_INSTR and the word-alignment helper align().
package cpu_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
    function automatic logic [WORD_W-1:0] align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifid_stage_if.sv
// ifid_stage_if: fetch-stage bus bundling hazard controls, branch redirect,
// instruction memory read data, the IF/ID register outputs and perf counters.
// Modports: master drives controls and Instr_i; slave is the fetch stage.
interface ifid_stage_if;
    import cpu_pkg::*;
    logic              PC_Write;
    logic              IFID_Write;
    logic              IFID_Flush;
    logic [WORD_W-1:0] Branch_Target;
    logic [WORD_W-1:0] Instr_i;
    logic [WORD_W-1:0] PC_o;
    logic [WORD_W-1:0] IFID_PC_Plus4;
    logic [WORD_W-1:0] IFID_Instr;
    logic              IFID_Valid;
    logic [WORD_W-1:0] Stall_Count;
    logic [WORD_W-1:0] Flush_Count;
    modport master (
        output PC_Write, IFID_Write, IFID_Flush, Branch_Target, Instr_i,
        input  PC_o, IFID_PC_Plus4, IFID_Instr, IFID_Valid, Stall_Count, Flush_Count
    );
    modport slave (
        input  PC_Write, IFID_Write, IFID_Flush, Branch_Target, Instr_i,
        output PC_o, IFID_PC_Plus4, IFID_Instr, IFID_Valid, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/ifid_stage_pc_register.sv
// pc_register: program counter with reset > flush > write > hold priority.
// Ports: clk_i, rst_i (sync, active-high), pc_write_i, flush_i, target_i, pc_o.
module pc_register
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_write_i,
    input  logic              flush_i,
    input  logic [WORD_W-1:0] target_i,
    output logic [WORD_W-1:0] pc_o
);
    logic [WORD_W-1:0] pc_q, pc_d;
    // Addition wraps naturally modulo 2^32; alignment keeps pc[1:0] at zero.
    always_comb pc_d = flush_i ? align(target_i) : pc_write_i ? pc_q + PC_INC : pc_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) pc_q <= align(RESET_PC);
        else       pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/ifid_stage.sv
// ifid_stage: instruction-fetch stage owning the PC and the IF/ID register.
// Ports: clk_i, rst_i (sync, active-high), bus (ifid_stage_if.slave).
// Optional feature macro PERF_COUNT_EN: saturating stall/flush counters;
// when undefined, Stall_Count and Flush_Count are tied to 0.
module ifid_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ifid_stage_if.slave  bus
);
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr_q, instr_d, plus4_q, plus4_d;
    logic              valid_q, valid_d;
    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pc_write_i (bus.PC_Write),
        .flush_i    (bus.IFID_Flush),
        .target_i   (bus.Branch_Target),
        .pc_o       (pc)
    );
    always_comb begin
        instr_d = bus.IFID_Flush ? NOP_INSTR : bus.IFID_Write ? bus.Instr_i : instr_q;
        plus4_d = bus.IFID_Flush ? '0 : bus.IFID_Write ? pc + PC_INC : plus4_q;
        valid_d = bus.IFID_Flush ? 1'b0 : bus.IFID_Write ? 1'b1 : valid_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            plus4_q <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            plus4_q <= plus4_d;
            valid_q <= valid_d;
        end
    end
    assign bus.PC_o          = pc;
    assign bus.IFID_Instr    = instr_q;
    assign bus.IFID_PC_Plus4 = plus4_q;
    assign bus.IFID_Valid    = valid_q;
`ifdef PERF_COUNT_EN
    logic [WORD_W-1:0] stall_q, stall_d, flush_q, flush_d;
    // A flush edge is not a stall even when IFID_Write is low.
    always_comb begin
        stall_d = (!bus.IFID_Flush && !bus.IFID_Write && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        flush_d = (bus.IFID_Flush && flush_q != '1) ? flush_q + 32'd1 : flush_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end
    assign bus.Stall_Count = stall_q;
    assign bus.Flush_Count = flush_q;
`else
    assign bus.Stall_Count = '0;
    assign bus.Flush_Count = '0;
`endif
endmodule
